second_largest_frame_ctrl: RTL



---
 rtl/second_largest_frame_ctrl_if.sv | 29 ++
 rtl/second_largest_frame_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/second_largest_frame_ctrl_if.sv
// Handshake bundle for second_largest_frame_ctrl: framed word stream in, per-frame result out.
// The slave modport is the controller's view; master is the surrounding source/consumer.
interface second_largest_frame_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_LEN    = 16,
   parameter int unsigned CNT_W      = $clog2(MAX_LEN + 1)
) ();
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_last;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_max;
   logic [DATA_WIDTH-1:0] m_second;
   logic [CNT_W-1:0]      m_count;
   logic                  m_short;
   logic                  m_trunc;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_max, m_second, m_count, m_short, m_trunc
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_max, m_second, m_count, m_short, m_trunc
   );
endinterface

// File: rtl/second_largest_frame_ctrl.sv
// Per-frame max / second-max tracker with a single buffered result.
// A frame ends on an accepted s_last beat or when it reaches MAX_LEN beats.
module second_largest_frame_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_LEN    = 16,
   parameter int unsigned CNT_W      = $clog2(MAX_LEN + 1)
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           clear,
   second_largest_frame_ctrl_if.slave     io_bus
);

   typedef enum logic [0:0] {StAccum, StResult} state_e;

   state_e                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_max, w_max_nxt, w_max_upd;
   logic [DATA_WIDTH-1:0] r_sec, w_sec_nxt, w_sec_upd;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [DATA_WIDTH-1:0] r_out_max, w_out_max_nxt;
   logic [DATA_WIDTH-1:0] r_out_sec, w_out_sec_nxt;
   logic [CNT_W-1:0]      r_out_cnt, w_out_cnt_nxt;
   logic                  r_out_short, w_out_short_nxt;
   logic                  r_out_trunc, w_out_trunc_nxt;
   logic                  w_beat;
   logic                  w_hit_max;
   logic                  w_frame_end;

   // Tracker values as they would be after absorbing the current word.
   always_comb begin
      w_max_upd = r_max;
      w_sec_upd = r_sec;
      if (io_bus.s_data > r_max) begin
         w_sec_upd = r_max;
         w_max_upd = io_bus.s_data;
      end else if (io_bus.s_data > r_sec) begin
         w_sec_upd = io_bus.s_data;
      end
   end

   assign w_cnt_inc   = r_cnt + CNT_W'(1);
   assign w_hit_max   = (w_cnt_inc == CNT_W'(MAX_LEN));
   assign w_beat      = io_bus.s_valid && (r_state == StAccum) && !clear;
   assign w_frame_end = w_beat && (io_bus.s_last || w_hit_max);

   always_comb begin
      w_state_nxt     = r_state;
      w_max_nxt       = r_max;
      w_sec_nxt       = r_sec;
      w_cnt_nxt       = r_cnt;
      w_out_max_nxt   = r_out_max;
      w_out_sec_nxt   = r_out_sec;
      w_out_cnt_nxt   = r_out_cnt;
      w_out_short_nxt = r_out_short;
      w_out_trunc_nxt = r_out_trunc;

      if (clear) begin
         // Abort: drop partial frame and any pending result, keep the last output fields.
         w_state_nxt = StAccum;
         w_max_nxt   = '0;
         w_sec_nxt   = '0;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            StAccum: begin
               if (w_frame_end) begin
                  w_out_max_nxt   = w_max_upd;
                  w_out_sec_nxt   = w_sec_upd;
                  w_out_cnt_nxt   = w_cnt_inc;
                  w_out_short_nxt = (w_cnt_inc < CNT_W'(2));
                  w_out_trunc_nxt = w_hit_max && !io_bus.s_last;
                  w_max_nxt       = '0;
                  w_sec_nxt       = '0;
                  w_cnt_nxt       = '0;
                  w_state_nxt     = StResult;
               end else if (w_beat) begin
                  w_max_nxt = w_max_upd;
                  w_sec_nxt = w_sec_upd;
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            StResult: begin
               if (io_bus.m_ready) begin
                  w_state_nxt = StAccum;
               end
            end
            default: w_state_nxt = StAccum;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= StAccum;
         r_max       <= '0;
         r_sec       <= '0;
         r_cnt       <= '0;
         r_out_max   <= '0;
         r_out_sec   <= '0;
         r_out_cnt   <= '0;
         r_out_short <= 1'b0;
         r_out_trunc <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_max       <= w_max_nxt;
         r_sec       <= w_sec_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_max   <= w_out_max_nxt;
         r_out_sec   <= w_out_sec_nxt;
         r_out_cnt   <= w_out_cnt_nxt;
         r_out_short <= w_out_short_nxt;
         r_out_trunc <= w_out_trunc_nxt;
      end
   end

   assign io_bus.s_ready  = (r_state == StAccum);
   assign io_bus.m_valid  = (r_state == StResult);
   assign io_bus.m_max    = r_out_max;
   assign io_bus.m_second = r_out_sec;
   assign io_bus.m_count  = r_out_cnt;
   assign io_bus.m_short  = r_out_short;
   assign io_bus.m_trunc  = r_out_trunc;

endmodule
